// File: rtl/impact_sram_seq.sv
// impact_sram_seq
//   Array-side access sequencer for the IMPACT SRAM test chip. Byte-serial
//   pad data is assembled into a write word; each write or read request runs
//   precharge -> wordline -> (sense) on the macro. Read words are returned
//   byte-wise on Data_Out.
//
//   Optional feature macro: IMPACT_SEQ_TRUNC_EN (adds Trunc_Enable, which
//   shortens the wordline phase to one cycle for margin characterization).
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   Data_In[7:0]      pad write byte, loaded when Data_In_Enable (IDLE only)
//   Data_In_Enable    load Data_In into write-buffer lane Byte_Select
//   Byte_Select[1:0]  lane for loading, byte-mode masking and read-out
//   Byte_Mode_Enable  write only the Byte_Select lane
//   WriteEnable       write request (sampled in IDLE)
//   ReadEnable        read request (sampled in IDLE)
//   addr              row address, sampled with the request
//   Trunc_Enable      (IMPACT_SEQ_TRUNC_EN only) one-cycle wordline
//   PreCharge         bitline precharge
//   WL_enable         wordline pulse
//   wl_addr           latched row address
//   bl_data           write buffer to the bitline drivers
//   byte_we           per-lane write-driver enable
//   sense_en          sense-amp fire
//   sense_data        sense-amp outputs
//   Data_Out[7:0]     registered read byte
//   data_out_valid    read word held in the read register
//   busy              sequence in progress
//   dbg_state[1:0]    FSM state (0 IDLE, 1 PRE, 2 WL, 3 SENSE)
//
// Handshake: WriteEnable/ReadEnable are level requests. A request is taken on
// any rising edge where the FSM is IDLE (busy low); busy high means not ready
// and requests seen then are dropped, not queued. Write wins over read.
module impact_sram_seq #(
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            Data_In,
    input  logic                  Data_In_Enable,
    input  logic [1:0]            Byte_Select,
    input  logic                  Byte_Mode_Enable,
    input  logic                  WriteEnable,
    input  logic                  ReadEnable,
    input  logic [ADDR_W-1:0]     addr,
`ifdef IMPACT_SEQ_TRUNC_EN
    input  logic                  Trunc_Enable,
`endif
    output logic                  PreCharge,
    output logic                  WL_enable,
    output logic [ADDR_W-1:0]     wl_addr,
    output logic [WORD_W-1:0]     bl_data,
    output logic [WORD_W/8-1:0]   byte_we,
    output logic                  sense_en,
    input  logic [WORD_W-1:0]     sense_data,
    output logic [7:0]            Data_Out,
    output logic                  data_out_valid,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int NB      = WORD_W / 8;
    localparam int CNT_MAX = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        WL    = 2'd2,
        SENSE = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;        // cycles remaining in the current phase, minus one
    logic              op_write;   // latched operation type
    logic [NB-1:0]     we_mask;    // write-lane mask latched at request time
    logic [WORD_W-1:0] rd_reg;
    logic [1:0]        lane_sel;
`ifdef IMPACT_SEQ_TRUNC_EN
    logic              trunc_q;
`endif

    assign dbg_state = state;

    // Out-of-range lane selects fall back to lane 0.
    always_comb begin
        lane_sel = 2'd0;
        if (int'(Byte_Select) < NB) lane_sel = Byte_Select;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            op_write       <= 1'b0;
            we_mask        <= '0;
            rd_reg         <= '0;
            PreCharge      <= 1'b0;
            WL_enable      <= 1'b0;
            wl_addr        <= '0;
            bl_data        <= '0;
            byte_we        <= '0;
            sense_en       <= 1'b0;
            Data_Out       <= '0;
            data_out_valid <= 1'b0;
            busy           <= 1'b0;
`ifdef IMPACT_SEQ_TRUNC_EN
            trunc_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Buffer loads only in IDLE so bl_data is frozen during a write.
                    if (Data_In_Enable) bl_data[lane_sel*8 +: 8] <= Data_In;
                    if (WriteEnable || ReadEnable) begin
                        state          <= PRE;
                        busy           <= 1'b1;
                        PreCharge      <= 1'b1;
                        cnt            <= CNT_W'(PRE_CYC - 1);
                        wl_addr        <= addr;
                        op_write       <= WriteEnable;
                        we_mask        <= Byte_Mode_Enable ? (NB'(1) << lane_sel) : '1;
                        data_out_valid <= 1'b0;
`ifdef IMPACT_SEQ_TRUNC_EN
                        trunc_q        <= Trunc_Enable;
`endif
                    end
                end
                PRE: begin
                    if (cnt == '0) begin
                        // Precharge drops on the same edge the wordline rises,
                        // so the two are never high together.
                        state     <= WL;
                        PreCharge <= 1'b0;
                        WL_enable <= 1'b1;
                        if (op_write) byte_we <= we_mask;
`ifdef IMPACT_SEQ_TRUNC_EN
                        cnt       <= trunc_q ? '0 : CNT_W'(WL_CYC - 1);
`else
                        cnt       <= CNT_W'(WL_CYC - 1);
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WL: begin
                    if (cnt == '0) begin
                        WL_enable <= 1'b0;
                        byte_we   <= '0;
                        if (op_write) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= SENSE;
                            sense_en <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SENSE: begin
                    sense_en       <= 1'b0;
                    rd_reg         <= sense_data;
                    data_out_valid <= 1'b1;
                    state          <= IDLE;
                    busy           <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Registered read-out mux; lags lane changes and captures by one cycle.
            Data_Out <= rd_reg[lane_sel*8 +: 8];
        end
    end

endmodule

// File: tb/tb_impact_sram_seq.sv
module tb_impact_sram_seq;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        data_in_enable;
  logic [1:0]  byte_select;
  logic        byte_mode_enable;
  logic        write_enable;
  logic        read_enable;
  logic [3:0]  addr;
  logic        trunc_enable;
  logic        pre_charge;
  logic        wl_enable;
  logic [3:0]  wl_addr;
  logic [31:0] bl_data;
  logic [3:0]  byte_we;
  logic        sense_en;
  logic [31:0] sense_data;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Simple SRAM array model: lanes written while the wordline is up.
  logic [31:0] mem [16];

  impact_sram_seq dut (
    .clk              (clk),
    .rst              (rst),
    .Data_In          (data_in),
    .Data_In_Enable   (data_in_enable),
    .Byte_Select      (byte_select),
    .Byte_Mode_Enable (byte_mode_enable),
    .WriteEnable      (write_enable),
    .ReadEnable       (read_enable),
    .addr             (addr),
`ifdef IMPACT_SEQ_TRUNC_EN
    .Trunc_Enable     (trunc_enable),
`endif
    .PreCharge        (pre_charge),
    .WL_enable        (wl_enable),
    .wl_addr          (wl_addr),
    .bl_data          (bl_data),
    .byte_we          (byte_we),
    .sense_en         (sense_en),
    .sense_data       (sense_data),
    .Data_Out         (data_out),
    .data_out_valid   (data_out_valid),
    .busy             (busy),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sense_data = mem[wl_addr];

  always @(posedge clk) begin
    if (wl_enable) begin
      for (int l = 0; l < 4; l++)
        if (byte_we[l]) mem[wl_addr][l*8 +: 8] <= bl_data[l*8 +: 8];
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle request; on return the bench sits in cycle 1.
  task automatic request(input logic wr, input logic rd, input logic [3:0] a);
    write_enable = wr;
    read_enable  = rd;
    addr         = a;
    tick();
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic load_byte(input logic [1:0] lane, input logic [7:0] b);
    byte_select    = lane;
    data_in        = b;
    data_in_enable = 1'b1;
    tick();
    data_in_enable = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b1;
    data_in = 8'h0; data_in_enable = 1'b0; byte_select = 2'd0;
    byte_mode_enable = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    addr = 4'h0; trunc_enable = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_pre",   pre_charge,     1'b0);
    check("rst_wl",    wl_enable,      1'b0);
    check("rst_addr",  wl_addr,        4'h0);
    check("rst_bl",    bl_data,        32'h0);
    check("rst_bwe",   byte_we,        4'h0);
    check("rst_sense", sense_en,       1'b0);
    check("rst_dout",  data_out,       8'h0);
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_busy",  busy,           1'b0);
    rst = 1'b0;
    tick();

    // full-word write
    load_byte(2'd0, 8'h11);
    load_byte(2'd1, 8'h22);
    load_byte(2'd2, 8'h33);
    load_byte(2'd3, 8'h44);
    byte_select = 2'd0;
    check("load_bl", bl_data, 32'h44332211);
    request(1'b1, 1'b0, 4'd5);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("w_pre_c%0d", c),   pre_charge, (c <= 2));
      check($sformatf("w_wl_c%0d", c),    wl_enable,  (c >= 3 && c <= 5));
      check($sformatf("w_bwe_c%0d", c),   byte_we,    (c >= 3 && c <= 5) ? 32'hF : 32'h0);
      check($sformatf("w_busy_c%0d", c),  busy,       (c <= 5));
      check($sformatf("w_sense_c%0d", c), sense_en,   1'b0);
      if (c == 1 || c == 6) tick(); else tick();
      if (c == 2) begin
        check("w_addr", wl_addr, 4'd5);
        check("w_bl",   bl_data, 32'h44332211);
      end
    end

    // read and byte select; bench is in cycle 7 of the write (IDLE)
    byte_select = 2'd2;
    request(1'b0, 1'b1, 4'd5);
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("r_pre_c%0d", c),   pre_charge,     (c <= 2));
      check($sformatf("r_wl_c%0d", c),    wl_enable,      (c >= 3 && c <= 5));
      check($sformatf("r_sense_c%0d", c), sense_en,       (c == 6));
      check($sformatf("r_busy_c%0d", c),  busy,           (c <= 6));
      check($sformatf("r_valid_c%0d", c), data_out_valid, (c >= 7));
      check($sformatf("r_bwe_c%0d", c),   byte_we,        4'h0);
      tick();
    end
    check("r_dout_lane2", data_out, 8'h33);
    byte_select = 2'd0;
    check("r_dout_hold", data_out, 8'h33);
    tick();
    check("r_dout_lane0", data_out, 8'h11);

    // byte mode write to row 3, lane 1
    byte_mode_enable = 1'b1;
    load_byte(2'd1, 8'hAB);
    check("bm_bl", bl_data, 32'h4433AB11);
    request(1'b1, 1'b0, 4'd3);
    byte_mode_enable = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      data_in        = 8'hFF;
      data_in_enable = (c <= 2);
      check($sformatf("bm_bwe_c%0d", c),   byte_we,        (c >= 3 && c <= 5) ? 32'h2 : 32'h0);
      check($sformatf("bm_bl_c%0d", c),    bl_data,        32'h4433AB11);
      check($sformatf("bm_valid_c%0d", c), data_out_valid, 1'b0);
      tick();
    end
    data_in_enable = 1'b0;

    // read back the byte-masked row
    byte_select = 2'd1;
    request(1'b0, 1'b1, 4'd3);
    for (int c = 1; c <= 7; c++) tick();
    check("bm_rd_valid", data_out_valid, 1'b1);
    check("bm_rd_dout",  data_out,       8'hAB);
    byte_select = 2'd3;
    tick();
    check("bm_rd_lane3", data_out, 8'h00);

    // request collision: write wins
    byte_select = 2'd0;
    request(1'b1, 1'b1, 4'd7);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("col_wl_c%0d", c),    wl_enable,      (c >= 3 && c <= 5));
      check($sformatf("col_sense_c%0d", c), sense_en,       1'b0);
      check($sformatf("col_busy_c%0d", c),  busy,           (c <= 5));
      check($sformatf("col_valid_c%0d", c), data_out_valid, 1'b0);
      check($sformatf("col_bwe_c%0d", c),   byte_we,        (c >= 3 && c <= 5) ? 32'hF : 32'h0);
      tick();
    end

    // reset during WL cycle 4 of a write
    request(1'b1, 1'b0, 4'd9);
    tick();
    tick();
    tick();
    check("mr_wl_before",   wl_enable, 1'b1);
    check("mr_busy_before", busy,      1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("mr_wl",   wl_enable, 1'b0);
    check("mr_busy", busy,      1'b0);
    check("mr_bwe",  byte_we,   4'h0);
    check("mr_addr", wl_addr,   4'h0);
    check("mr_bl",   bl_data,   32'h0);
    tick();
    rst = 1'b0;
    tick();

    // read row 7 after reset release: standard timing
    byte_select = 2'd0;
    request(1'b0, 1'b1, 4'd7);
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("ar_pre_c%0d", c),   pre_charge,     (c <= 2));
      check($sformatf("ar_wl_c%0d", c),    wl_enable,      (c >= 3 && c <= 5));
      check($sformatf("ar_sense_c%0d", c), sense_en,       (c == 6));
      check($sformatf("ar_valid_c%0d", c), data_out_valid, (c >= 7));
      tick();
    end
    check("ar_dout", data_out, 8'h11);

    // truncated wordline (or full length when the feature is compiled out)
    trunc_enable = 1'b1;
    request(1'b1, 1'b0, 4'd2);
    trunc_enable = 1'b0;
    for (int c = 1; c <= 6; c++) begin
`ifdef IMPACT_SEQ_TRUNC_EN
      check($sformatf("tr_wl_c%0d", c),   wl_enable, (c == 3));
      check($sformatf("tr_busy_c%0d", c), busy,      (c <= 3));
`else
      check($sformatf("tr_wl_c%0d", c),   wl_enable, (c >= 3 && c <= 5));
      check($sformatf("tr_busy_c%0d", c), busy,      (c <= 5));
`endif
      check($sformatf("tr_pre_c%0d", c), pre_charge, (c <= 2));
      tick();
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
